// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port front end that shares one combinational ALU.
// A request is granted in IDLE, its operands are held while the external ALU
// evaluates them in EXEC, and the registered result is offered to the
// granted port in RESP until that port takes it.
module alu_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [31:0]      req0_srca,
   input  logic [31:0]      req0_srcb,
   input  logic [31:0]      req1_srca,
   input  logic [31:0]      req1_srcb,
   input  logic [2:0]       req0_alucontrol,
   input  logic [2:0]       req1_alucontrol,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   input  logic             rsp0_ready,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic [31:0]      alu_srca,
   output logic [31:0]      alu_srcb,
   output logic [2:0]       alu_control,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        grant0;
   logic        grant1;
   logic        accept;
   logic        complete;
   logic        win_id;
   logic        last_grant;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [2:0]  op_c;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Arbitration and sequencing: grant only from IDLE, release only when the winner takes its result.
   always_comb begin
      state_next = state;
      grant0     = 1'b0;
      grant1     = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid && req1_valid) begin
               // last_grant = 1 means port 1 went last, so port 0 is owed the tie
               if ((FIXED_PRIO != 0) || last_grant) begin
                  grant0 = 1'b1;
               end else begin
                  grant1 = 1'b1;
               end
            end else if (req0_valid) begin
               grant0 = 1'b1;
            end else if (req1_valid) begin
               grant1 = 1'b1;
            end
            if (grant0 || grant1) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            complete = win_id ? rsp1_ready : rsp0_ready;
            if (complete) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign accept      = grant0 | grant1;
   // ready is gated by reset so a requester holding valid during reset sees no grant
   assign req0_ready  = reset_n & grant0;
   assign req1_ready  = reset_n & grant1;
   assign rsp0_valid  = (state == RESP) && !win_id;
   assign rsp1_valid  = (state == RESP) && win_id;
   assign busy        = (state != IDLE);
   assign alu_srca    = op_a;
   assign alu_srcb    = op_b;
   assign alu_control = op_c;

   // Datapath: latch the winner's operands, capture the ALU result, count completions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_a       <= '0;
         op_b       <= '0;
         op_c       <= '0;
         win_id     <= 1'b0;
         last_grant <= 1'b1;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         ops_done   <= '0;
      end else begin
         if (accept) begin
            op_a       <= grant1 ? req1_srca : req0_srca;
            op_b       <= grant1 ? req1_srcb : req0_srcb;
            op_c       <= grant1 ? req1_alucontrol : req0_alucontrol;
            win_id     <= grant1;
            last_grant <= grant1;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
         end
         if (complete) begin
            ops_done <= ops_done + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives a round-robin instance (CNT_W=16) and a fixed-priority
// instance (CNT_W=2) with the same stimulus, each with its own ALU model,
// and checks grants, latency, results, back-pressure, reset and counter wrap.
module tb_alu_arbiter;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic        clk;
   logic        reset_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
   logic [2:0]  req0_alucontrol, req1_alucontrol;
   logic        rsp0_ready, rsp1_ready;

   logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
   logic [31:0] rr_rsp_result, rr_alu_srca, rr_alu_srcb, rr_alu_result;
   logic        rr_rsp_zero, rr_alu_zero, rr_busy;
   logic [2:0]  rr_alu_control;
   logic [15:0] rr_ops_done;

   logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
   logic [31:0] fp_rsp_result, fp_alu_srca, fp_alu_srcb, fp_alu_result;
   logic        fp_rsp_zero, fp_alu_zero, fp_busy;
   logic [2:0]  fp_alu_control;
   logic [1:0]  fp_ops_done;

   int errors = 0;
   int checks = 0;
   int exp_ops = 0;

   typedef struct {
      logic        v0;
      logic        v1;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [2:0]  c0;
      logic [31:0] a1;
      logic [31:0] b1;
      logic [2:0]  c1;
      logic        rr_win;
      logic [31:0] rr_res;
      logic        rr_z;
      logic        fp_win;
      logic [31:0] fp_res;
      logic        fp_z;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_XOR:  return a ^ b;
         OP_SUB:  return a - b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign rr_alu_result = alu_model(rr_alu_control, rr_alu_srca, rr_alu_srcb);
   assign rr_alu_zero   = (rr_alu_result == 32'd0);
   assign fp_alu_result = alu_model(fp_alu_control, fp_alu_srca, fp_alu_srcb);
   assign fp_alu_zero   = (fp_alu_result == 32'd0);

   alu_arbiter #(.FIXED_PRIO(0), .CNT_W(16)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(rr_req0_ready), .req1_ready(rr_req1_ready),
      .req0_srca(req0_srca), .req0_srcb(req0_srcb),
      .req1_srca(req1_srca), .req1_srcb(req1_srcb),
      .req0_alucontrol(req0_alucontrol), .req1_alucontrol(req1_alucontrol),
      .rsp0_valid(rr_rsp0_valid), .rsp1_valid(rr_rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(rr_rsp_result), .rsp_zero(rr_rsp_zero),
      .alu_srca(rr_alu_srca), .alu_srcb(rr_alu_srcb), .alu_control(rr_alu_control),
      .alu_result(rr_alu_result), .alu_zero(rr_alu_zero),
      .busy(rr_busy), .ops_done(rr_ops_done)
   );

   alu_arbiter #(.FIXED_PRIO(1), .CNT_W(2)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
      .req0_srca(req0_srca), .req0_srcb(req0_srcb),
      .req1_srca(req1_srca), .req1_srcb(req1_srcb),
      .req0_alucontrol(req0_alucontrol), .req1_alucontrol(req1_alucontrol),
      .rsp0_valid(fp_rsp0_valid), .rsp1_valid(fp_rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero),
      .alu_srca(fp_alu_srca), .alu_srcb(fp_alu_srcb), .alu_control(fp_alu_control),
      .alu_result(fp_alu_result), .alu_zero(fp_alu_zero),
      .busy(fp_busy), .ops_done(fp_ops_done)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_counts();
      check_output("rr ops_done", 32'(rr_ops_done), 32'(exp_ops));
      check_output("fp ops_done", 32'(fp_ops_done), 32'(exp_ops % 4));
   endtask

   // One full operation: grant in IDLE, hold in EXEC, response in RESP.
   task automatic apply_stimulus(input vec_t v);
      @(negedge clk);
      check_counts();
      req0_valid = v.v0; req0_srca = v.a0; req0_srcb = v.b0; req0_alucontrol = v.c0;
      req1_valid = v.v1; req1_srca = v.a1; req1_srcb = v.b1; req1_alucontrol = v.c1;
      #1;
      check_output("rr idle busy", 32'(rr_busy), 32'd0);
      check_output("rr req0_ready grant", 32'(rr_req0_ready), 32'(!v.rr_win));
      check_output("rr req1_ready grant", 32'(rr_req1_ready), 32'(v.rr_win));
      check_output("fp req0_ready grant", 32'(fp_req0_ready), 32'(!v.fp_win));
      check_output("fp req1_ready grant", 32'(fp_req1_ready), 32'(v.fp_win));
      @(negedge clk);
      check_output("rr exec ready", 32'({rr_req0_ready, rr_req1_ready}), 32'd0);
      check_output("rr exec busy", 32'(rr_busy), 32'd1);
      check_output("rr exec rsp_valid", 32'({rr_rsp0_valid, rr_rsp1_valid}), 32'd0);
      check_output("rr alu_srca", rr_alu_srca, v.rr_win ? v.a1 : v.a0);
      check_output("fp alu_srca", fp_alu_srca, v.fp_win ? v.a1 : v.a0);
      @(negedge clk);
      check_output("rr rsp0_valid", 32'(rr_rsp0_valid), 32'(!v.rr_win));
      check_output("rr rsp1_valid", 32'(rr_rsp1_valid), 32'(v.rr_win));
      check_output("rr rsp_result", rr_rsp_result, v.rr_res);
      check_output("rr rsp_zero", 32'(rr_rsp_zero), 32'(v.rr_z));
      check_output("fp rsp0_valid", 32'(fp_rsp0_valid), 32'(!v.fp_win));
      check_output("fp rsp1_valid", 32'(fp_rsp1_valid), 32'(v.fp_win));
      check_output("fp rsp_result", fp_rsp_result, v.fp_res);
      check_output("fp rsp_zero", 32'(fp_rsp_zero), 32'(v.fp_z));
      exp_ops++;
   endtask

   // Main sequence: reset, vector table, back-pressure, reset mid-operation.
   initial begin
      vecs[0] = '{1'b1, 1'b1, 32'd3, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR, 1'b0, 32'd0,   1'b1, 1'b0, 32'd0, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 32'd3, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR, 1'b1, 32'hFF,  1'b0, 1'b0, 32'd0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 32'd3, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR, 1'b0, 32'd0,   1'b1, 1'b0, 32'd0, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, OP_ADD,   1'b0, 32'd12,  1'b0, 1'b0, 32'd12, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 32'd0, 32'd0, OP_ADD, 32'hFFFF0000, 32'h0000FFFF, OP_AND, 1'b1, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 32'd0, 32'd0, OP_ADD, 32'h1200, 32'h0034, OP_OR, 1'b1, 32'h1234, 1'b0, 1'b1, 32'h1234, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, OP_SLT, 32'hFFFFFFFF, 32'd1, OP_ADD, 1'b0, 32'd1, 1'b0, 1'b0, 32'd1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, OP_SLT, 32'hFFFFFFFF, 32'd1, OP_ADD, 1'b1, 32'd0, 1'b1, 1'b0, 32'd1, 1'b0};

      reset_n = 1'b0;
      req0_valid = 1'b1; req0_srca = 32'd9; req0_srcb = 32'd9; req0_alucontrol = OP_ADD;
      req1_valid = 1'b1; req1_srca = 32'd9; req1_srcb = 32'd9; req1_alucontrol = OP_ADD;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_output("reset req_ready", 32'({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready}), 32'd0);
      check_output("reset busy", 32'({rr_busy, fp_busy}), 32'd0);
      check_output("reset rsp_valid", 32'({rr_rsp0_valid, rr_rsp1_valid}), 32'd0);
      check_output("reset rsp_result", rr_rsp_result, 32'd0);
      check_output("reset alu_srca", rr_alu_srca, 32'd0);
      check_counts();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i]);
      end

      // Back-pressure on port 1 while port 0 waits with a pending request.
      @(negedge clk);
      check_counts();
      rsp1_ready = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_srca = 32'd10; req1_srcb = 32'd3; req1_alucontrol = OP_SUB;
      #1;
      check_output("bp rr req1_ready", 32'(rr_req1_ready), 32'd1);
      check_output("bp fp req1_ready", 32'(fp_req1_ready), 32'd1);
      @(negedge clk);
      req0_valid = 1'b1; req0_srca = 32'd1; req0_srcb = 32'd1; req0_alucontrol = OP_ADD;
      #1;
      check_output("bp exec req0_ready", 32'({rr_req0_ready, fp_req0_ready}), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         check_output("bp rsp1_valid held", 32'({rr_rsp1_valid, fp_rsp1_valid}), 32'b11);
         check_output("bp rsp_result held", rr_rsp_result, 32'd7);
         check_output("bp busy held", 32'(rr_busy), 32'd1);
         check_output("bp req0_ready low", 32'({rr_req0_ready, fp_req0_ready}), 32'd0);
         check_output("bp ops_done held", 32'(rr_ops_done), 32'(exp_ops));
         if (i < 5) @(negedge clk);
      end
      rsp1_ready = 1'b1;
      #1;
      check_output("complete cycle req0_ready", 32'({rr_req0_ready, fp_req0_ready}), 32'd0);
      exp_ops++;
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      check_output("bp rsp1_valid released", 32'({rr_rsp1_valid, fp_rsp1_valid}), 32'd0);
      check_counts();
      check_output("waiting req0 granted", 32'({rr_req0_ready, fp_req0_ready}), 32'b11);
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      check_output("port0 after bp rsp0_valid", 32'({rr_rsp0_valid, fp_rsp0_valid}), 32'b11);
      check_output("port0 after bp result", rr_rsp_result, 32'd2);
      exp_ops++;

      // Reset in the middle of an operation.
      @(negedge clk);
      check_counts();
      req0_valid = 1'b1; req0_srca = 32'd3; req0_srcb = 32'd3; req0_alucontrol = OP_SUB;
      req1_valid = 1'b1; req1_srca = 32'hF0; req1_srcb = 32'h0F; req1_alucontrol = OP_XOR;
      @(negedge clk);
      check_output("pre-reset busy", 32'(rr_busy), 32'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check_output("midop reset busy", 32'({rr_busy, fp_busy}), 32'd0);
      check_output("midop reset rsp_result", rr_rsp_result, 32'd0);
      check_output("midop reset alu_srca", rr_alu_srca, 32'd0);
      check_output("midop reset alu_control", 32'(rr_alu_control), 32'd0);
      exp_ops = 0;
      check_counts();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("no rsp after reset", 32'({rr_rsp0_valid, rr_rsp1_valid, fp_rsp0_valid, fp_rsp1_valid}), 32'd0);
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check_output("post-reset tie rr", 32'({rr_req0_ready, rr_req1_ready}), 32'b10);
      check_output("post-reset tie fp", 32'({fp_req0_ready, fp_req1_ready}), 32'b10);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration, 1 = port 0 always wins.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the completed-operation counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  request present on port 0 / 1.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports req0_srca, req0_srcb, req1_srca, req1_srcb  input  32  operands.
REQ-008 SHALL have ports req0_alucontrol / req1_alucontrol  input  3  ALU operation code, using the shared constants encoding.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid  output  1  result available for port 0 / 1.
REQ-010 SHALL have ports rsp0_ready / rsp1_ready  input  1  requester takes the result.
REQ-011 SHALL have ports rsp_result  output  32 and rsp_zero  output  1  registered ALU result and zero flag, shared by both ports.
REQ-012 SHALL have ports alu_srca, alu_srcb  output  32 and alu_control  output  3  driving the shared combinational ALU.
REQ-013 SHALL have ports alu_result  input  32 and alu_zero  input  1  returned from the shared ALU.
REQ-014 SHALL have ports busy  output  1 (state != IDLE) and ops_done  output  CNT_W (completed-operation count).

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE with at least one reqN_valid high, SHALL pick a winner, assert only the winner's reqN_ready combinationally in that cycle, latch its srca/srcb/alucontrol and the winner id, and go to EXEC.
REQ-017 In IDLE with no valid, SHALL stay in IDLE with both ready low.
REQ-018 Round-robin (FIXED_PRIO=0): single requester wins; on a tie, the port not granted last wins; last-grant SHALL update only on acceptance.
REQ-019 Fixed priority (FIXED_PRIO=1): port 0 SHALL win every tie.
REQ-020 alu_srca/alu_srcb/alu_control SHALL always equal the latched operand registers.
REQ-021 In EXEC, SHALL register alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP (exactly one cycle).
REQ-022 In RESP, SHALL assert rspN_valid for the latched winner only; rsp_result/rsp_zero SHALL stay stable while valid is high.
REQ-023 In RESP, on rspN_valid && rspN_ready SHALL increment ops_done (wrapping modulo 2^CNT_W) and return to IDLE; otherwise hold RESP indefinitely.
REQ-024 Latency: request accepted in cycle N -> rspN_valid high in cycle N+2; minimum issue interval 3 cycles per operation.
REQ-025 Both reqN_ready SHALL be low in EXEC and RESP; requests arriving then wait (requesters hold valid and operands until ready).
REQ-026 rspN_ready asserted before rspN_valid SHALL have no effect; ready of the non-granted port SHALL be ignored.
REQ-027 A new request SHALL not be accepted in the same cycle a response completes (IDLE entered first).

Reset
REQ-028 While reset_n is low, SHALL force state IDLE, all ready/valid outputs 0, operand registers, alu_* outputs, rsp_result, rsp_zero and ops_done to 0, busy 0, last-grant to port 1 (so port 0 wins the first tie).
REQ-029 Reset asserted mid-operation (EXEC or RESP) SHALL abandon the operation with no response and no ops_done increment.

Verification
REQ-030 Single request: port0 ADD srca=5 srcb=7 in cycle N -> req0_ready in N, rsp0_valid in N+2 with rsp_result=12, rsp_zero=0, ops_done=1.
REQ-031 Tie, round-robin: both valid continuously with port0 SUB 3-3, port1 XOR 0xF0^0x0F -> port0 first (result 0, zero=1), then port1 (result 0xFF), then port0 again.
REQ-032 Tie, FIXED_PRIO=1: both valid for two ops -> port0 granted both times, port1 waits with ready low.
REQ-033 Back-pressure: rsp1_ready held low 5 cycles after rsp1_valid -> rsp1_valid, rsp_result and state held; req0_ready stays low; completes on first cycle rsp1_ready high.
REQ-034 Reset mid-op: reset_n low during EXEC -> all outputs 0 asynchronously, no rsp_valid after release, next tie granted to port 0.
REQ-035 Counter wrap with CNT_W=2: complete 5 operations -> ops_done sequence 1,2,3,0,1.
